ram_bus_responder: RTL and testbench
====================================

// Module: ram_bus_responder
// PURPOSE
//   Bus-side responder for the simple dual-port RAM (dual_ram): accepts single-beat valid/ready
//   read/write requests from a core LSU/fetch port, drives the RAM's write and read ports, and
//   returns one valid/ready response per request. The RAM has no byte enables, so partial writes
//   use read-modify-write. Exactly one request is outstanding at a time.
// PARAMETERS
//   DW     32    data width; fixed at 32; byte-strobe width SW = DW/8 = 4
//   AW     12    RAM word-address width
//   DEPTH  4096  RAM depth in words; must be <= 2**AW
//   ADDR_W 32    request byte-address width
// PORTS
//   clk        in   1       single clock; all logic on posedge
//   rstn       in   1       reset, synchronous, active-low
//   req_valid  in   1       request valid
//   req_ready  out  1       request ready; equals (state==IDLE)
//   req_we     in   1       1 = write, 0 = read
//   req_addr   in   ADDR_W  byte address; word index = req_addr[AW+1:2]
//   req_wdata  in   DW      write data
//   req_wstrb  in   SW      byte-lane write strobes; ignored for reads
//   rsp_valid  out  1       response valid
//   rsp_ready  in   1       response accept
//   rsp_rdata  out  DW      read data; 0 for writes and errors
//   rsp_err    out  1       1 = misaligned or out-of-range access
// BEHAVIOUR
//   Reset (rstn=0 at posedge): state<=IDLE; rsp_valid, rsp_err, rsp_rdata <= 0. An in-flight RMW
//     is dropped and no RAM write is issued. RAM ren/wen are held 0 while rstn=0.
//   Accept: the request is accepted at the posedge with req_valid & req_ready (cycle T).
//     RAM ports for the first access are driven combinationally from req_* in cycle T.
//   Error: req_addr[1:0]!=0, or any req_addr[ADDR_W-1:AW+2]!=0, or word index >= DEPTH.
//     No RAM access. Go to RESP with rsp_err=1 and rsp_rdata=0. rsp_valid is high from T+1.
//   FSM states: IDLE, RD_WAIT, RMW, RESP.
//     IDLE, read     -> ren=1, r_addr=idx              -> RD_WAIT
//     IDLE, wstrb=F  -> wen=1, w_addr=idx, w_data=wdata -> RESP (rsp_valid high from T+1)
//     IDLE, wstrb=0  -> no RAM access                  -> RESP (T+1)
//     IDLE, partial  -> ren=1; latch idx, wdata, wstrb -> RMW
//     RD_WAIT        -> rsp_rdata<=r_data              -> RESP (rsp_valid high from T+2)
//     RMW            -> merged[8i+7:8i] = wstrb[i] ? wdata byte : r_data byte;
//                       wen=1 with merged data          -> RESP (T+2)
//     RESP           -> hold rsp_* stable until rsp_valid & rsp_ready, then go to IDLE
//                       with rsp_valid<=0. A new request cannot be accepted in that cycle.
//   Write data reaches the RAM array at the posedge where wen=1. A read issued afterwards
//     returns the new data; no forwarding is needed because only one request is outstanding.
//   req_* are sampled only in IDLE; changes to them in other states are ignored.
//   rsp_valid never drops without a handshake. rsp_err=0 on every non-error response.
// STRUCTURE
//   Package ram_bus_pkg: state enum (IDLE, RD_WAIT, RMW, RESP); constant SW = DW/8;
//     function byte_merge(old, new, strb).
//   One sub-module: a dual_ram instance (DW, AW, DEPTH passed through; clk, rstn shared).
//   The FSM, address decode and merge datapath stay in this module.
// TESTING
//   1. Write 0xDEADBEEF, strb=F, addr 0x10 -> rsp at T+1, err=0; read 0x10 -> rdata=0xDEADBEEF at T+2.
//   2. After test 1, write 0x00001234, strb=4'b0011, addr 0x10 -> rsp at T+2; read back = 0xDEAD1234.
//   3. Read addr 0x4002 (misaligned) -> err=1, rdata=0. Read addr 0x4000 (DEPTH=4096) -> err=1.
//        Neither issues ren or wen.
//   4. Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable; req_ready=0 throughout.
//   5. Write strb=4'b0100 to a word, assert rstn=0 during RMW -> no wen pulse; word is unchanged;
//        rsp_valid=0.
//   6. 100 back-to-back random read/write requests with random rsp_ready stalls -> responses match
//        a scoreboard model in order.

Source files
------------

// File: rtl/ram_bus_pkg.sv
// Shared types and helpers for the RAM bus responder.
package ram_bus_pkg;

   localparam int BUS_DW = 32;
   localparam int SW     = BUS_DW / 8;

   // Responder FSM encoding
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      RMW     = 2'd2,
      RESP    = 2'd3
   } state_t;

   // Replace the bytes of old_data selected by strb with the matching bytes of new_data.
   function automatic logic [BUS_DW-1:0] byte_merge(input logic [BUS_DW-1:0] old_data,
                                                    input logic [BUS_DW-1:0] new_data,
                                                    input logic [SW-1:0]     strb);
      logic [BUS_DW-1:0] merged;
      merged = old_data;
      for (int i = 0; i < SW; i++) begin
         if (strb[i]) merged[8*i +: 8] = new_data[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dual_ram.sv
// Simple dual-port RAM: one write port, one registered read port, same clock.
module dual_ram #(
   parameter int DW    = 32,
   parameter int AW    = 12,
   parameter int DEPTH = 4096
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          wen,
   input  logic [AW-1:0] w_addr,
   input  logic [DW-1:0] w_data,
   input  logic          ren,
   input  logic [AW-1:0] r_addr,
   output logic [DW-1:0] r_data
);

   logic [DW-1:0] mem [DEPTH];

   // Array write; contents are not cleared by reset.
   always_ff @(posedge clk) begin
      if (wen) mem[w_addr] <= w_data;
   end

   // Registered read; data is available the cycle after ren.
   always_ff @(posedge clk) begin
      if (!rstn)    r_data <= '0;
      else if (ren) r_data <= mem[r_addr];
   end

endmodule

// File: rtl/ram_bus_responder.sv
// Valid/ready bus responder in front of dual_ram; one request in flight,
// partial writes done as read-modify-write.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | ready for a request; first RAM access driven from req_*
//   RD_WAIT | read issued, RAM data arrives this cycle
//   RMW     | old word available, write back the byte-merged word
//   RESP    | response presented, waiting for rsp_ready
module ram_bus_responder
   import ram_bus_pkg::*;
#(
   parameter int DW     = 32,
   parameter int AW     = 12,
   parameter int DEPTH  = 4096,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DW-1:0]     req_wdata,
   input  logic [SW-1:0]     req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_rdata,
   output logic              rsp_err
);

   state_t        state, state_nxt;
   logic [AW-1:0] idx, idx_q;
   logic [DW-1:0] wdata_q;
   logic [SW-1:0] wstrb_q;
   logic          addr_err;
   logic          accept;
   logic          ren, wen;
   logic          ram_ren, ram_wen;
   logic [AW-1:0] ram_r_addr, ram_w_addr;
   logic [DW-1:0] ram_w_data, ram_r_data;

   assign idx       = req_addr[AW+1:2];
   assign addr_err  = (req_addr[1:0] != 2'b00)
                    || ((req_addr >> (AW + 2)) != '0)
                    || (int'(idx) >= DEPTH);
   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;

   // RAM strobes are forced low during reset so an interrupted RMW never writes.
   assign ram_ren = ren && rstn;
   assign ram_wen = wen && rstn;

   // Next-state and RAM port control.
   always_comb begin
      state_nxt  = state;
      ren        = 1'b0;
      wen        = 1'b0;
      ram_r_addr = idx;
      ram_w_addr = idx;
      ram_w_data = req_wdata;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               if (addr_err) begin
                  state_nxt = RESP;
               end else if (!req_we) begin
                  ren       = 1'b1;
                  state_nxt = RD_WAIT;
               end else if (req_wstrb == '1) begin
                  wen       = 1'b1;
                  state_nxt = RESP;
               end else if (req_wstrb == '0) begin
                  state_nxt = RESP;
               end else begin
                  ren       = 1'b1;
                  state_nxt = RMW;
               end
            end
         end
         RD_WAIT: state_nxt = RESP;
         RMW: begin
            wen        = 1'b1;
            ram_w_addr = idx_q;
            ram_w_data = byte_merge(ram_r_data, wdata_q, wstrb_q);
            state_nxt  = RESP;
         end
         RESP: begin
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and response outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  rsp_err   <= addr_err;
                  rsp_rdata <= '0;
                  rsp_valid <= (state_nxt == RESP);
               end
            end
            RD_WAIT: begin
               rsp_rdata <= ram_r_data;
               rsp_err   <= 1'b0;
               rsp_valid <= 1'b1;
            end
            RMW: begin
               rsp_valid <= 1'b1;
            end
            RESP: begin
               if (rsp_ready) rsp_valid <= 1'b0;
            end
            default: rsp_valid <= 1'b0;
         endcase
      end
   end

   // Capture the partial-write operands; only consumed in RMW.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q   <= idx;
         wdata_q <= req_wdata;
         wstrb_q <= req_wstrb;
      end
   end

   dual_ram #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk    (clk),
      .rstn   (rstn),
      .wen    (ram_wen),
      .w_addr (ram_w_addr),
      .w_data (ram_w_data),
      .ren    (ram_ren),
      .r_addr (ram_r_addr),
      .r_data (ram_r_data)
   );

endmodule

// File: tb/tb_ram_bus_responder.sv
// Directed and scoreboarded checks for ram_bus_responder.
module tb_ram_bus_responder;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_pass  = 0;
   int n_total = 0;
   int ram_act = 0;
   int wen_cnt = 0;

   logic [31:0] model [16];

   always #5 clk = ~clk;

   ram_bus_responder dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always @(posedge clk) begin
      if (dut.ram_ren || dut.ram_wen) ram_act <= ram_act + 1;
      if (dut.ram_wen) wen_cnt <= wen_cnt + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Present one request from IDLE, wait for the response, optionally stall, then accept it.
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int stall,
                         output logic [31:0] rdata, output logic err, output int lat);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = strb;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = rsp_rdata;
      err   = rsp_err;
      repeat (stall) begin
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          base;
      logic [31:0] held;

      rstn      = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // full write then read back
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat);
      chk("t1_wr_lat", lat, 1);
      chk("t1_wr_err", er, 0);
      chk("t1_wr_rdata", rd, 0);
      chk("t1_post_valid", rsp_valid, 0);
      chk("t1_post_ready", req_ready, 1);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      chk("t1_rd_lat", lat, 2);
      chk("t1_rd_err", er, 0);
      chk("t1_rd_data", rd, 32'hDEADBEEF);

      // partial write via read-modify-write
      do_req(1'b1, 32'h10, 32'h00001234, 4'b0011, 0, rd, er, lat);
      chk("t2_rmw_lat", lat, 2);
      chk("t2_rmw_err", er, 0);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      chk("t2_rd_data", rd, 32'hDEAD1234);

      // zero-strobe write: no RAM change, response next cycle
      do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat);
      chk("t2_zs_lat", lat, 1);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      chk("t2_zs_data", rd, 32'hDEAD1234);

      // error accesses issue no RAM traffic
      base = ram_act;
      do_req(1'b0, 32'h4002, 32'h0, 4'h0, 0, rd, er, lat);
      chk("t3_mis_err", er, 1);
      chk("t3_mis_rdata", rd, 0);
      chk("t3_mis_lat", lat, 1);
      do_req(1'b0, 32'h4000, 32'h0, 4'h0, 0, rd, er, lat);
      chk("t3_oor_err", er, 1);
      chk("t3_oor_rdata", rd, 0);
      do_req(1'b1, 32'h0001_0000, 32'h5, 4'hF, 0, rd, er, lat);
      chk("t3_hi_err", er, 1);
      chk("t3_no_ram", ram_act - base, 0);
      do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
      chk("t3_ok_err", er, 0);

      // response held stable under back-pressure
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      held = rsp_rdata;
      chk("t4_data", held, 32'hDEAD1234);
      req_valid = 1'b1; req_addr = 32'h14;
      for (int i = 0; i < 5; i++) begin
         chk("t4_valid", rsp_valid, 1);
         chk("t4_rdata", rsp_rdata, 32'hDEAD1234);
         chk("t4_req_ready", req_ready, 0);
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("t4_release", rsp_valid, 0);

      // reset during RMW drops the write
      do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
      req_wdata = 32'h00AA0000; req_wstrb = 4'b0100;
      @(posedge clk); #1;
      req_valid = 1'b0;
      base = wen_cnt;
      rstn = 1'b0;
      @(posedge clk); #1;
      chk("t5_no_wen", wen_cnt - base, 0);
      chk("t5_valid", rsp_valid, 0);
      rstn = 1'b1;
      @(posedge clk); #1;
      chk("t5_ready", req_ready, 1);
      do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat);
      chk("t5_word", rd, 32'h11223344);

      // random traffic against a reference model
      for (int w = 0; w < 16; w++) begin
         model[w] = 32'hA5000000 + w * 32'h01010101;
         do_req(1'b1, 32'h100 + w * 4, model[w], 4'hF, 0, rd, er, lat);
      end
      for (int n = 0; n < 100; n++) begin
         int          op;
         int          w;
         logic [31:0] wd;
         logic [3:0]  st;
         logic [31:0] a;
         op = $urandom_range(0, 9);
         w  = $urandom_range(0, 15);
         wd = $urandom;
         st = 4'($urandom_range(0, 15));
         a  = 32'h100 + w * 4;
         if (op == 0) begin
            do_req(1'b0, a | 32'h1, wd, st, $urandom_range(0, 3), rd, er, lat);
            chk("t6_err_flag", er, 1);
            chk("t6_err_data", rd, 0);
         end else if (op <= 3) begin
            do_req(1'b1, a, wd, st, $urandom_range(0, 3), rd, er, lat);
            for (int b = 0; b < 4; b++) begin
               if (st[b]) model[w][8*b +: 8] = wd[8*b +: 8];
            end
            chk("t6_wr_err", er, 0);
            chk("t6_wr_data", rd, 0);
         end else begin
            do_req(1'b0, a, wd, st, $urandom_range(0, 3), rd, er, lat);
            chk("t6_rd_err", er, 0);
            chk("t6_rd_data", rd, model[w]);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
